// File: rtl/bitstream_ena_ctrl_pkg.sv
// Shared encodings for the bitstream front-end enable controller: debug modes and FSM states.
package bitstream_ena_ctrl_pkg;

    localparam logic [1:0] ENA_MODE_RUN    = 2'd0;
    localparam logic [1:0] ENA_MODE_STEP   = 2'd1;
    localparam logic [1:0] ENA_MODE_FREEZE = 2'd2;
    localparam logic [1:0] ENA_MODE_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ENA_ST_FRZ       = 2'd0,
        ENA_ST_RUN       = 2'd1,
        ENA_ST_STEP_ARM  = 2'd2,
        ENA_ST_STEP_FIRE = 2'd3
    } ena_state_e;

endpackage

// File: rtl/bitstream_ena_ctrl_stall_counter.sv
// Per-channel stall counter: saturates at all-ones, clear takes priority over increment.
module ena_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/bitstream_ena_ctrl.sv
// Enable generator for the bitstream/decode front end: per-channel gating by global enable and
// selected valid source, RUN/STEP/FREEZE debug modes and saturating per-channel stall counters.
module bitstream_ena_ctrl
    import bitstream_ena_ctrl_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int N_CH  = 16,
    parameter int CNT_W = 16,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [N_SRC-1:0]      i_src_valid,
    input  logic [N_CH-1:0]       i_ch_req,
    input  logic [N_CH-1:0]       i_ch_need_valid,
    input  logic [N_CH*SEL_W-1:0] i_ch_src_sel,
    input  logic [1:0]            i_mode,
    input  logic                  i_step,
    input  logic                  i_stall_clr,
    output logic [N_CH-1:0]       o_ch_en,
    output logic [N_CH*CNT_W-1:0] o_stall_cnt,
    output logic                  o_stall_any,
    output logic                  o_step_done
);

    ena_state_e      state;
    logic [1:0]      mode_q;
    logic            step_q;
    logic            step_edge;
    logic            active;
    logic [N_CH-1:0] ch_valid;
    logic [N_CH-1:0] gate;
    logic [N_CH-1:0] stall;
    logic [N_CH-1:0] counted;

    // Out-of-range selects read as not valid.
    function automatic logic src_valid_of(input logic [SEL_W-1:0] sel,
                                          input logic [N_SRC-1:0] vld);
        logic v;
        v = 1'b0;
        for (int s = 0; s < N_SRC; s++) begin
            if (sel == SEL_W'(s)) v = vld[s];
        end
        return v;
    endfunction

    always_comb begin
        ch_valid = '0;
        gate     = '0;
        stall    = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_valid[k] = src_valid_of(i_ch_src_sel[k*SEL_W +: SEL_W], i_src_valid);
            gate[k]     = i_en & i_ch_req[k] & (~i_ch_need_valid[k] | ch_valid[k]);
            stall[k]    = i_en & i_ch_req[k] & i_ch_need_valid[k] & ~ch_valid[k];
        end
    end

    assign active    = (state == ENA_ST_RUN) || (state == ENA_ST_STEP_FIRE);
    assign o_ch_en   = active ? gate  : '0;
    assign counted   = active ? stall : '0;
    assign step_edge = i_step & ~step_q;

    // Mode is registered first, so every transition lags the i_mode change by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ENA_ST_FRZ;
            mode_q      <= ENA_MODE_FREEZE;
            step_q      <= 1'b0;
            o_step_done <= 1'b0;
            o_stall_any <= 1'b0;
        end else begin
            mode_q      <= i_mode;
            step_q      <= i_step;
            o_step_done <= (state == ENA_ST_STEP_FIRE);
            o_stall_any <= |counted;
            case (mode_q)
                ENA_MODE_RUN: state <= ENA_ST_RUN;
                ENA_MODE_STEP: begin
                    case (state)
                        ENA_ST_STEP_ARM:  if (step_edge) state <= ENA_ST_STEP_FIRE;
                        ENA_ST_STEP_FIRE: state <= ENA_ST_STEP_ARM;
                        default:          state <= ENA_ST_STEP_ARM;
                    endcase
                end
                default: state <= ENA_ST_FRZ;
            endcase
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_cnt
        ena_stall_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (counted[k]),
            .clr  (i_stall_clr),
            .cnt  (o_stall_cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_bitstream_ena_ctrl.sv
// Directed plus randomized bench for bitstream_ena_ctrl against a cycle-level behavioural model.
module tb_bitstream_ena_ctrl;

    localparam int N_SRC = 3;
    localparam int N_CH  = 16;
    localparam int CNT_W = 4;
    localparam int SEL_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  rst_n;
    logic                  i_en;
    logic [N_SRC-1:0]      i_src_valid;
    logic [N_CH-1:0]       i_ch_req;
    logic [N_CH-1:0]       i_ch_need_valid;
    logic [N_CH*SEL_W-1:0] i_ch_src_sel;
    logic [1:0]            i_mode;
    logic                  i_step;
    logic                  i_stall_clr;
    logic [N_CH-1:0]       o_ch_en;
    logic [N_CH*CNT_W-1:0] o_stall_cnt;
    logic                  o_stall_any;
    logic                  o_step_done;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: which debug phase we are in, as plain flags.
    logic [1:0] md_mode;
    bit         md_run, md_fire, md_armed, md_any, md_done, md_prev_step;
    int         md_cnt[N_CH];

    bitstream_ena_ctrl #(
        .N_SRC(N_SRC), .N_CH(N_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_en           (i_en),
        .i_src_valid    (i_src_valid),
        .i_ch_req       (i_ch_req),
        .i_ch_need_valid(i_ch_need_valid),
        .i_ch_src_sel   (i_ch_src_sel),
        .i_mode         (i_mode),
        .i_step         (i_step),
        .i_stall_clr    (i_stall_clr),
        .o_ch_en        (o_ch_en),
        .o_stall_cnt    (o_stall_cnt),
        .o_stall_any    (o_stall_any),
        .o_step_done    (o_step_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_valid(int k);
        int sel;
        sel = int'((i_ch_src_sel >> (k * SEL_W)) & ((1 << SEL_W) - 1));
        if (sel >= N_SRC) return 1'b0;
        return i_src_valid[sel];
    endfunction

    function automatic bit exp_stall(int k);
        return i_en && i_ch_req[k] && i_ch_need_valid[k] && !exp_valid(k);
    endfunction

    task automatic model_reset();
        md_mode = 2'd2;
        md_run = 0; md_fire = 0; md_armed = 0;
        md_any = 0; md_done = 0; md_prev_step = 0;
        for (int k = 0; k < N_CH; k++) md_cnt[k] = 0;
    endtask

    task automatic model_clock();
        bit act, any, edge_seen;
        act = md_run || md_fire;
        any = 0;
        for (int k = 0; k < N_CH; k++) begin
            if (act && exp_stall(k)) any = 1;
            if (i_stall_clr) md_cnt[k] = 0;
            else if (act && exp_stall(k) && md_cnt[k] < CMAX) md_cnt[k] = md_cnt[k] + 1;
        end
        md_any  = any;
        md_done = md_fire;
        edge_seen = i_step && !md_prev_step;
        if (md_mode == 2'd0) begin
            md_run = 1; md_fire = 0; md_armed = 0;
        end else if (md_mode == 2'd1) begin
            if (md_fire) begin
                md_fire = 0; md_armed = 1;
            end else if (md_armed) begin
                if (edge_seen) begin md_fire = 1; md_armed = 0; end
            end else begin
                md_run = 0; md_armed = 1;
            end
        end else begin
            md_run = 0; md_fire = 0; md_armed = 0;
        end
        md_mode      = i_mode;
        md_prev_step = i_step;
    endtask

    task automatic check_all();
        logic [N_CH-1:0]       e;
        logic [N_CH*CNT_W-1:0] c;
        for (int k = 0; k < N_CH; k++) begin
            e[k] = (md_run || md_fire) && i_en && i_ch_req[k] &&
                   (!i_ch_need_valid[k] || exp_valid(k));
            c[k*CNT_W +: CNT_W] = CNT_W'(md_cnt[k]);
        end
        chk("ch_en", 64'(o_ch_en), 64'(e));
        chk("stall_cnt", 64'(o_stall_cnt), 64'(c));
        chk("stall_any", 64'(o_stall_any), 64'(md_any));
        chk("step_done", 64'(o_step_done), 64'(md_done));
    endtask

    // Called between posedge+1 and the next negedge; returns at posedge+1.
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(int k);
        return o_stall_cnt[k*CNT_W +: CNT_W];
    endfunction

    initial begin
        int n_en, n_done;
        rst_n           = 1'b0;
        i_en            = 1'b1;
        i_src_valid     = 3'b010;
        i_ch_req        = 16'h0001;
        i_ch_need_valid = 16'h0001;
        i_ch_src_sel    = 32'h0000_0001;
        i_mode          = 2'd0;
        i_step          = 1'b0;
        i_stall_clr     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ch_en", 64'(o_ch_en), 64'd0);
        chk("rst_cnt", 64'(o_stall_cnt), 64'd0);
        chk("rst_any", 64'(o_stall_any), 64'd0);
        chk("rst_done", 64'(o_step_done), 64'd0);

        // Release in RUN: channel 0 enabled on the second cycle after release.
        rst_n = 1'b1;
        tick();
        chk("t1_en_early", 64'(o_ch_en[0]), 64'd0);
        tick();
        chk("t1_en0", 64'(o_ch_en[0]), 64'd1);

        // Channel 3 stalls on source 2.
        i_ch_req        = 16'h0009;
        i_ch_need_valid = 16'h0009;
        i_ch_src_sel    = 32'h0000_0081;
        i_stall_clr     = 1'b1;
        tick();
        i_stall_clr = 1'b0;
        repeat (10) tick();
        chk("t2_cnt3", 64'(cnt_of(3)), 64'd10);
        chk("t2_any", 64'(o_stall_any), 64'd1);
        chk("t2_cnt0", 64'(cnt_of(0)), 64'd0);
        i_stall_clr = 1'b1;
        tick();
        i_stall_clr = 1'b0;
        chk("t2_clr", 64'(cnt_of(3)), 64'd0);

        repeat (20) tick();
        chk("t3_sat", 64'(cnt_of(3)), 64'd15);

        // Single-step: one enabled cycle per rising edge of i_step.
        i_mode          = 2'd1;
        i_ch_req        = 16'h0001;
        i_ch_need_valid = 16'h0001;
        tick();
        tick();
        chk("t4_arm_en", 64'(o_ch_en), 64'd0);
        i_step = 1'b1;
        n_en = 0;
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            n_en += int'(o_ch_en[0]);
            tick();
            n_done += int'(o_step_done);
            if (i == 1) chk("t4_done_after_fire", 64'(o_step_done), 64'd1);
        end
        chk("t4_en_cycles", 64'(n_en), 64'd1);
        chk("t4_done_pulses", 64'(n_done), 64'd1);
        i_step = 1'b0;
        tick();
        i_step = 1'b1;
        tick();
        chk("t4_refire", 64'(o_ch_en[0]), 64'd1);
        tick();
        chk("t4_redone", 64'(o_step_done), 64'd1);
        chk("t4_after_en", 64'(o_ch_en), 64'd0);
        i_step = 1'b0;

        // Freeze with a stall pending, then resume.
        i_mode          = 2'd2;
        i_ch_req        = 16'h0009;
        i_ch_need_valid = 16'h0009;
        i_ch_src_sel    = 32'h0000_0081;
        i_stall_clr     = 1'b1;
        tick();
        i_stall_clr = 1'b0;
        repeat (6) tick();
        chk("t5_frz_en", 64'(o_ch_en), 64'd0);
        chk("t5_frz_cnt3", 64'(cnt_of(3)), 64'd0);
        i_mode = 2'd0;
        tick();
        chk("t5_lag_en", 64'(o_ch_en), 64'd0);
        tick();
        chk("t5_resume_en", 64'(o_ch_en), 64'h0001);
        tick();
        chk("t5_resume_cnt3", 64'(cnt_of(3)), 64'd1);

        // Async reset while a step is firing, then reserved mode acts as freeze.
        i_mode = 2'd1;
        tick();
        tick();
        i_step = 1'b1;
        tick();
        chk("t6_fire_en", 64'(o_ch_en[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en", 64'(o_ch_en), 64'd0);
        chk("t6_rst_cnt", 64'(o_stall_cnt), 64'd0);
        chk("t6_rst_any", 64'(o_stall_any), 64'd0);
        model_reset();
        i_mode = 2'd3;
        i_step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_rsvd_en", 64'(o_ch_en), 64'd0);
        chk("t6_rsvd_cnt", 64'(o_stall_cnt), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: i_mode = 2'd0;
                    4, 5, 6:    i_mode = 2'd1;
                    7, 8:       i_mode = 2'd2;
                    default:    i_mode = 2'd3;
                endcase
            end
            if ($urandom_range(0, 2) == 0) i_step = ~i_step;
            if ($urandom_range(0, 19) == 0) i_ch_src_sel = $urandom();
            i_src_valid     = N_SRC'($urandom());
            i_ch_req        = N_CH'($urandom());
            i_ch_need_valid = N_CH'($urandom());
            i_en            = ($urandom_range(0, 9) != 0);
            i_stall_clr     = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
